// File: rtl/cpu_control_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer: ARM condition check, datapath strobes, data-memory handshake.
// Optional saturating performance counters are built when CTRL_PERF_CNT_EN is defined.
module cpu_control_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [31:0]      instr,
  input  logic [3:0]       flags,
  input  logic             mem_ack,
  output logic             ir_load,
  output logic             pc_en,
  output logic             pc_branch,
  output logic             reg_we,
  output logic             link_we,
  output logic             base_we,
  output logic             flags_we,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_byte,
  output logic             undef,
  output logic             mem_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [31:20]      ir_q, ir_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cond_pass;
  logic              base_wb;
  logic              n_f, z_f, c_f, v_f;
  logic              unused_instr;

  // Only the cond/class/control fields are ever consulted after FETCH.
  assign unused_instr = ^instr[19:0];
  assign {n_f, z_f, c_f, v_f} = flags;
  assign base_wb = ~ir_q[24] | ir_q[21];
  assign state   = state_q;

  always_comb begin
    case (ir_q[31:28])
      4'h0:    cond_pass = z_f;
      4'h1:    cond_pass = ~z_f;
      4'h2:    cond_pass = c_f;
      4'h3:    cond_pass = ~c_f;
      4'h4:    cond_pass = n_f;
      4'h5:    cond_pass = ~n_f;
      4'h6:    cond_pass = v_f;
      4'h7:    cond_pass = ~v_f;
      4'h8:    cond_pass = c_f & ~z_f;
      4'h9:    cond_pass = ~c_f | z_f;
      4'ha:    cond_pass = (n_f == v_f);
      4'hb:    cond_pass = (n_f != v_f);
      4'hc:    cond_pass = ~z_f & (n_f == v_f);
      4'hd:    cond_pass = z_f | (n_f != v_f);
      4'he:    cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = '0;
    ir_load   = 1'b0;
    pc_en     = 1'b0;
    pc_branch = 1'b0;
    reg_we    = 1'b0;
    link_we   = 1'b0;
    base_we   = 1'b0;
    flags_we  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    undef     = 1'b0;
    mem_err   = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        ir_d    = instr[31:20];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (!cond_pass) begin
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else if (ir_q[27:26] == 2'b11) begin
          undef   = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q[27:26])
          2'b00: begin
            // TST/TEQ/CMP/CMN only touch the flags
            reg_we   = (ir_q[24:23] != 2'b10);
            flags_we = ir_q[20];
            pc_en    = 1'b1;
          end
          2'b01: state_d = S_MEM;
          default: begin
            pc_en     = 1'b1;
            pc_branch = ir_q[25];
            link_we   = ir_q[25] & ir_q[24];
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_we   = ~ir_q[20];
        mem_byte = ir_q[22];
        wait_d   = wait_q + 1'b1;
        // ack wins even on the final allowed cycle
        if (mem_ack) begin
          if (ir_q[20]) begin
            state_d = S_WB;
          end else begin
            pc_en   = 1'b1;
            base_we = base_wb;
            state_d = S_FETCH;
          end
        end else if (wait_q == WAIT_LAST) begin
          mem_err = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        base_we = base_wb;
        pc_en   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      wait_q  <= wait_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d, stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (pc_en && (retired_q != '1)) retired_d = retired_q + 1'b1;
    if ((state_q == S_MEM) && !mem_ack && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: per-instruction expected cycle traces built from the ISA rules, compared every cycle.
module tb_cpu_control_fsm;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int MEM_TO = 255;

  localparam logic [11:0] M_IRL = 12'h800, M_PCE = 12'h400, M_PCB = 12'h200, M_RWE = 12'h100;
  localparam logic [11:0] M_LWE = 12'h080, M_BWE = 12'h040, M_FWE = 12'h020, M_MRQ = 12'h010;
  localparam logic [11:0] M_MWE = 12'h008, M_MBY = 12'h004, M_UND = 12'h002, M_MER = 12'h001;

  typedef struct packed {
    logic [2:0]  st;
    logic [11:0] strb;
    logic [3:0]  rcnt;
    logic [3:0]  scnt;
  } exp_t;

  logic        clk;
  logic        nreset;
  logic [31:0] instr;
  logic [3:0]  flags;
  logic        mem_ack;
  logic        ir_load, pc_en, pc_branch, reg_we, link_we, base_we, flags_we;
  logic        mem_req, mem_we, mem_byte, undef, mem_err;
  logic [2:0]  state;
  logic [3:0]  retired_cnt, stall_cnt;
  logic [11:0] strobes;

  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t exp_q[$];
  exp_t bld_rec[$];
  bit   bld_ack[$];
  bit   bld_dec[$];
  logic [3:0] m_ret, m_stall;

  cpu_control_fsm #(.CNT_W(4), .MEM_TIMEOUT(MEM_TO)) dut (
    .clk(clk), .nreset(nreset), .instr(instr), .flags(flags), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_en(pc_en), .pc_branch(pc_branch), .reg_we(reg_we),
    .link_we(link_we), .base_we(base_we), .flags_we(flags_we), .mem_req(mem_req),
    .mem_we(mem_we), .mem_byte(mem_byte), .undef(undef), .mem_err(mem_err),
    .state(state), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  assign strobes = {ir_load, pc_en, pc_branch, reg_we, link_we, base_we, flags_we,
                    mem_req, mem_we, mem_byte, undef, mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
  endtask

  // Condition table expressed as base predicate per pair, odd codes invert it.
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit base;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = f[2];
      3'd1:    base = f[1];
      3'd2:    base = f[3];
      3'd3:    base = f[0];
      3'd4:    base = f[1] && !f[2];
      3'd5:    base = (f[3] == f[0]);
      default: base = !f[2] && (f[3] == f[0]);
    endcase
    return base ^ c[0];
  endfunction

  task automatic add_cyc(input logic [2:0] st, input logic [11:0] s, input bit ack, input bit dec);
    exp_t r;
    r.st = st; r.strb = s; r.rcnt = m_ret; r.scnt = m_stall;
    bld_rec.push_back(r);
    bld_ack.push_back(ack);
    bld_dec.push_back(dec);
    if (PERF && (s & M_PCE) != 12'h0 && m_ret != 4'hF) m_ret = m_ret + 4'd1;
    if (PERF && (s & M_MRQ) != 12'h0 && !ack && m_stall != 4'hF) m_stall = m_stall + 4'd1;
  endtask

  task automatic build(input logic [31:0] ins, input logic [3:0] fl, input int ack_at);
    logic [11:0] s;
    bit load, wb;
    int n;
    load = ins[20];
    wb   = !ins[24] || ins[21];
    bld_rec.delete(); bld_ack.delete(); bld_dec.delete();
    add_cyc(3'd1, M_IRL, 1'b0, 1'b0);
    if (!cond_ok(ins[31:28], fl)) begin add_cyc(3'd2, M_PCE, 1'b0, 1'b1); return; end
    if (ins[27:26] == 2'b11) begin add_cyc(3'd2, M_UND | M_PCE, 1'b0, 1'b1); return; end
    add_cyc(3'd2, 12'h0, 1'b0, 1'b1);
    if (ins[27:26] == 2'b00) begin
      s = M_PCE;
      if (ins[24:21] < 4'd8 || ins[24:21] > 4'd11) s = s | M_RWE;
      if (ins[20]) s = s | M_FWE;
      add_cyc(3'd3, s, 1'b0, 1'b0);
    end else if (ins[27:26] == 2'b10) begin
      s = M_PCE;
      if (ins[25]) s = s | M_PCB | (ins[24] ? M_LWE : 12'h0);
      add_cyc(3'd3, s, 1'b0, 1'b0);
    end else begin
      add_cyc(3'd3, 12'h0, 1'b0, 1'b0);
      n = (ack_at >= 1 && ack_at <= MEM_TO) ? ack_at : MEM_TO;
      for (int k = 1; k <= n; k++) begin
        s = M_MRQ | (load ? 12'h0 : M_MWE) | (ins[22] ? M_MBY : 12'h0);
        if (k == n && k == ack_at && !load) s = s | M_PCE | (wb ? M_BWE : 12'h0);
        if (k == n && k != ack_at) s = s | M_MER | M_PCE;
        add_cyc(3'd4, s, k == ack_at, 1'b0);
      end
      if (load && n == ack_at) add_cyc(3'd5, M_RWE | M_PCE | (wb ? M_BWE : 12'h0), 1'b0, 1'b0);
    end
  endtask

  // Entered and left at posedge+1 of a FETCH cycle; abort_at>0 stops after that many cycles.
  task automatic run(input logic [31:0] ins, input logic [3:0] fl, input int ack_at, input int abort_at,
                     output int ncyc, output int nreq, output int nerr);
    build(ins, fl, ack_at);
    ncyc = bld_rec.size();
    if (abort_at > 0) ncyc = abort_at;
    nreq = 0; nerr = 0;
    for (int i = 0; i < ncyc; i++) exp_q.push_back(bld_rec[i]);
    for (int i = 0; i < ncyc; i++) begin
      instr   = (i == 0) ? ins : ~ins;
      flags   = bld_dec[i] ? fl : ~fl;
      mem_ack = bld_ack[i];
      #2;
      nreq += int'(mem_req);
      nerr += int'(mem_err);
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    nreset = 1'b0; instr = 32'h0; flags = 4'h0; mem_ack = 1'b0;
    m_ret = 4'h0; m_stall = 4'h0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rst_strobes", 32'(strobes), 32'h0);
      chk("rst_state", 32'(state), 32'h0);
      chk("rst_counters", 32'({retired_cnt, stall_cnt}), 32'h0);
    end
    @(posedge clk); #1;
    nreset = 1'b1;
    @(negedge clk);
    chk("idle_state", 32'(state), 32'h0);
    chk("idle_strobes", 32'(strobes), 32'h0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc_state", 32'(state), 32'(e.st));
      chk("cyc_strobes", 32'(strobes), 32'(e.strb));
      chk("cyc_retired", 32'(retired_cnt), 32'(e.rcnt));
      chk("cyc_stall", 32'(stall_cnt), 32'(e.scnt));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, nq, ne;
    nreset = 1'b1; instr = 32'h0; flags = 4'h0; mem_ack = 1'b0;
    #2;
    do_reset(3);
    run(32'hE0810002, 4'h0, 0, 0, nc, nq, ne);  chk("add_cycles", 32'(nc), 32'd3);
    run(32'h0A000001, 4'h0, 0, 0, nc, nq, ne);  chk("beq_nt_cycles", 32'(nc), 32'd2);
    run(32'h0A000001, 4'h4, 0, 0, nc, nq, ne);  chk("beq_t_cycles", 32'(nc), 32'd3);
    run(32'hEB000004, 4'h0, 0, 0, nc, nq, ne);
    run(32'hE1500001, 4'h0, 0, 0, nc, nq, ne);
    run(32'hE0910002, 4'h0, 0, 0, nc, nq, ne);
    run(32'hF0810002, 4'hF, 0, 0, nc, nq, ne);  chk("nv_cycles", 32'(nc), 32'd2);
    run(32'hC0810002, 4'h9, 0, 0, nc, nq, ne);
    run(32'hD0810002, 4'h9, 0, 0, nc, nq, ne);
    run(32'hEC000000, 4'h0, 0, 0, nc, nq, ne);
    run(32'h0C000000, 4'h0, 0, 0, nc, nq, ne);
    run(32'hE5B12004, 4'h0, 3, 0, nc, nq, ne);
    chk("ldr_cycles", 32'(nc), 32'd7);
    chk("ldr_req_cycles", 32'(nq), 32'd3);
    chk("ldr_stall", 32'(stall_cnt), PERF ? 32'd2 : 32'd0);
    run(32'hE5D12000, 4'h0, 1, 0, nc, nq, ne);
    run(32'hE4812004, 4'h0, 2, 0, nc, nq, ne);
    run(32'hE5812000, 4'h0, 1, 0, nc, nq, ne);  chk("str_cycles", 32'(nc), 32'd4);
    run(32'hE5812000, 4'h0, 0, 0, nc, nq, ne);
    chk("to_cycles", 32'(nc), 32'd258);
    chk("to_req_cycles", 32'(nq), 32'd255);
    chk("to_err_pulses", 32'(ne), 32'd1);
    run(32'hE5812000, 4'h0, 255, 0, nc, nq, ne);
    chk("lastack_req_cycles", 32'(nq), 32'd255);
    chk("lastack_err_pulses", 32'(ne), 32'd0);
    chk("retired_sat", 32'(retired_cnt), PERF ? 32'd15 : 32'd0);
    chk("stall_sat", 32'(stall_cnt), PERF ? 32'd15 : 32'd0);
    run(32'hE5812000, 4'h0, 0, 6, nc, nq, ne);
    #1;
    chk("abort_req_before", 32'(mem_req), 32'd1);
    nreset = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_strobes", 32'(strobes), 32'h0);
    do_reset(1);
    run(32'hE0810002, 4'h0, 0, 0, nc, nq, ne);
    run(32'hE5B12004, 4'h0, 2, 0, nc, nq, ne);
    chk("post_rst_stall", 32'(stall_cnt), PERF ? 32'd1 : 32'd0);
    chk("post_rst_retired", 32'(retired_cnt), PERF ? 32'd2 : 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
